// File: rtl/mul32_seq.sv
// mul32_seq: sequential unsigned WIDTH x WIDTH shift-add multiplier (radix-2).
// One partial product is added per clock, so a multiply takes exactly WIDTH
// cycles in RUN, followed by a single DONE cycle.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   start       request, accepted only in IDLE
//   a, b        multiplicand / multiplier, captured on the accepting edge
//   busy        high while the multiply is running
//   done        one-cycle pulse; product is valid from this cycle on
//   product_lo  low half of a*b (feeds mux32_8)
//   product_hi  high half of a*b
module mul32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] product_hi
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;
  logic             last;

  // One shift-add step: conditionally add the multiplicand into the upper
  // half at WIDTH+1 bits, then shift the whole accumulator right by one so
  // the add's carry lands in the MSB of the upper half.
  function automatic logic [2*WIDTH-1:0] shift_add(
    input logic [WIDTH-1:0] hi,
    input logic [WIDTH-1:0] lo,
    input logic [WIDTH-1:0] m
  );
    logic [WIDTH:0] sum;
    sum = lo[0] ? ({1'b0, hi} + {1'b0, m}) : {1'b0, hi};
    return {sum, lo[WIDTH-1:1]};
  endfunction

  always_comb begin
    {hi_nxt, lo_nxt} = shift_add(acc_hi, acc_lo, mcand);
    last             = (cnt == CNT_W'(WIDTH - 1));
  end

  // Next-state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mcand      <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      cnt        <= '0;
      product_lo <= '0;
      product_hi <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a;
            acc_hi <= '0;
            acc_lo <= b;
            cnt    <= '0;
          end
        end
        RUN: begin
          acc_hi <= hi_nxt;
          acc_lo <= lo_nxt;
          cnt    <= cnt + CNT_W'(1);
          // Result registers only load on the final step so downstream
          // never sees a partial accumulator.
          if (last) begin
            product_hi <= hi_nxt;
            product_lo <= lo_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul32_seq.sv
module tb_mul32_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] product_lo;
  logic [W-1:0] product_hi;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  mul32_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .product_lo (product_lo),
    .product_hi (product_hi)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 running with a countdown of cycles
  // left, 2 the single result-valid pulse. Product from plain multiplication.
  int             m_phase = 0;
  int             m_left  = 0;
  logic [2*W-1:0] m_pend  = '0;
  logic [2*W-1:0] m_prod  = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0;
      m_left  = 0;
      m_prod  = '0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase = 1;
          m_left  = W;
          m_pend  = {32'b0, a} * {32'b0, b};
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_phase = 2;
            m_prod  = m_pend;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", 64'(busy), 64'(m_phase == 1));
      chk("done", 64'(done), 64'(m_phase == 2));
      chk("product", {product_hi, product_lo}, m_prod);
    end
  end

  // Start one multiply from IDLE at a negedge; optionally pulse a spurious
  // start during RUN at cycle inj. Returns one cycle after done.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] elo, input logic [31:0] ehi,
                        input int inj);
    int          cyc;
    logic [31:0] prev;
    bit          held;
    prev  = product_lo;
    held  = 1'b1;
    start = 1'b1;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    cyc   = 0;
    while (!done && cyc < 40) begin
      if (product_lo !== prev) held = 1'b0;
      if (cyc == inj) begin
        start = 1'b1;
        a     = 32'd7;
        b     = 32'd3;
      end else if (cyc == inj + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("latency", 64'(cyc), 64'd32);
    chk("lo", 64'(product_lo), 64'(elo));
    chk("hi", 64'(product_hi), 64'(ehi));
    chk("held_during_run", 64'(held), 64'd1);
    @(negedge clk);
    chk("done_drop", 64'(done), 64'd0);
    chk("lo_hold", 64'(product_lo), 64'(elo));
    chk("hi_hold", 64'(product_hi), 64'(ehi));
  endtask

  initial begin
    bit seen_done;
    reset = 1'b1;
    start = 1'b1;
    a     = 32'd15;
    b     = 32'd15;
    @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_lo", 64'(product_lo), 64'd0);
    chk("rst_hi", 64'(product_hi), 64'd0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", 64'(busy), 64'd0);

    run_op(32'd15, 32'd15, 32'd225, 32'd0, -1);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, -1);
    run_op(32'h80000000, 32'd2, 32'd0, 32'd1, -1);

    run_op(32'd15, 32'd15, 32'd225, 32'd0, 5);
    repeat (3) begin
      @(negedge clk);
      chk("no_second_op", 64'(busy), 64'd0);
    end

    // Abort a multiply with reset in the middle of RUN
    start = 1'b1;
    a     = 32'd100;
    b     = 32'd100;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrun_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_lo", 64'(product_lo), 64'd0);
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    chk("abort_no_done", 64'(seen_done), 64'd0);

    run_op(32'd0, 32'd12345, 32'd0, 32'd0, -1);
    run_op(32'd3, 32'd5, 32'd15, 32'd0, -1);
    run_op(32'd6, 32'd7, 32'd42, 32'd0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
